// File: rtl/flit_decompressor.sv
// flit_decompressor
//   Receive side of the NoC flit compressor. Each accepted compressed payload is
//   expanded back to a full flit using its 3-bit encoding tag. The flit is pushed
//   into a small output FIFO that absorbs link backpressure. A history register
//   holds the last flit written, and the repeat tag (3'b010) uses it.
//
// Ports
//   clk          in   clock, rising edge
//   rst_n        in   asynchronous active-low reset
//   in_valid     in   compressed flit present
//   in_ready     out  FIFO not full; depends on state only
//   in_data      in   compressed payload, LSB-aligned
//   in_en        in   encoding tag (ignored for head flits)
//   in_is_head   in   head flit, always passed through raw
//   out_valid    out  FIFO not empty
//   out_ready    in   consumer accepts the head-of-FIFO flit
//   out_data     out  reconstructed flit (zero while FIFO empty)
//   out_is_head  out  head marker travelling with the flit
//   err_pulse    out  one-cycle pulse after an accepted flit with an illegal tag
//   flit_count   out  flits written into the FIFO since reset, saturating

module flit_decompressor #(
    parameter int unsigned FLIT_W     = 128,
    parameter int unsigned FIFO_DEPTH = 2,
    parameter int unsigned CNT_W      = 16
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              in_valid,
    output logic              in_ready,
    input  logic [FLIT_W-1:0] in_data,
    input  logic [2:0]        in_en,
    input  logic              in_is_head,
    output logic              out_valid,
    input  logic              out_ready,
    output logic [FLIT_W-1:0] out_data,
    output logic              out_is_head,
    output logic              err_pulse,
    output logic [CNT_W-1:0]  flit_count
);

    localparam int unsigned NumWords = FLIT_W / 32;
    localparam int unsigned AW       = (FIFO_DEPTH > 1) ? $clog2(FIFO_DEPTH) : 1;
    localparam int unsigned OW       = $clog2(FIFO_DEPTH + 1);

    // Storage
    logic [FLIT_W-1:0] mem_data_q [FIFO_DEPTH];
    logic              mem_head_q [FIFO_DEPTH];

    logic [AW-1:0]     wr_ptr_q, wr_ptr_d;
    logic [AW-1:0]     rd_ptr_q, rd_ptr_d;
    logic [OW-1:0]     count_q, count_d;
    logic [FLIT_W-1:0] history_q, history_d;
    logic [CNT_W-1:0]  flit_count_q, flit_count_d;
    logic              err_q, err_d;

    logic [FLIT_W-1:0] flit;
    logic              legal;
    logic              accept;
    logic              push;
    logic              pop;
    logic              full;
    logic              empty;

    // Decode
    always_comb begin
        flit  = '0;
        legal = 1'b1;
        if (in_is_head) begin
            flit = in_data;
        end else begin
            case (in_en)
                3'b000: flit = in_data;
                3'b001: flit = '0;
                // history_q already holds the most recently written flit, so
                // chained repeats pick up entries still sitting in the FIFO.
                3'b010: flit = history_q;
                3'b011: begin
                    for (int k = 0; k < NumWords; k++) begin
                        flit[32*k +: 32] = in_data[31:0];
                    end
                end
                3'b100: flit[63:0] = in_data[63:0];
                3'b101: begin
                    for (int k = 0; k < NumWords; k++) begin
                        flit[32*k +: 32] = {{16{in_data[16*k+15]}}, in_data[16*k +: 16]};
                    end
                end
                default: legal = 1'b0;
            endcase
        end
    end

    // Handshake and occupancy
    always_comb begin
        full   = (count_q == OW'(FIFO_DEPTH));
        empty  = (count_q == '0);
        accept = in_valid && !full;
        push   = accept && (in_is_head || legal);
        pop    = !empty && out_ready;
    end

    assign in_ready  = !full;
    assign out_valid = !empty;

    // Next state
    always_comb begin
        wr_ptr_d     = wr_ptr_q;
        rd_ptr_d     = rd_ptr_q;
        count_d      = count_q;
        history_d    = history_q;
        flit_count_d = flit_count_q;
        err_d        = accept && !in_is_head && !legal;

        if (push) begin
            wr_ptr_d  = (wr_ptr_q == AW'(FIFO_DEPTH - 1)) ? '0 : wr_ptr_q + 1'b1;
            history_d = flit;
            if (flit_count_q != '1) begin
                flit_count_d = flit_count_q + 1'b1;
            end
        end
        if (pop) begin
            rd_ptr_d = (rd_ptr_q == AW'(FIFO_DEPTH - 1)) ? '0 : rd_ptr_q + 1'b1;
        end
        case ({push, pop})
            2'b10:   count_d = count_q + 1'b1;
            2'b01:   count_d = count_q - 1'b1;
            default: count_d = count_q;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wr_ptr_q     <= '0;
            rd_ptr_q     <= '0;
            count_q      <= '0;
            history_q    <= '0;
            flit_count_q <= '0;
            err_q        <= 1'b0;
        end else begin
            wr_ptr_q     <= wr_ptr_d;
            rd_ptr_q     <= rd_ptr_d;
            count_q      <= count_d;
            history_q    <= history_d;
            flit_count_q <= flit_count_d;
            err_q        <= err_d;
        end
    end

    // Entry contents need no reset: outputs are masked while the FIFO is empty.
    always_ff @(posedge clk) begin
        if (push) begin
            mem_data_q[wr_ptr_q] <= flit;
            mem_head_q[wr_ptr_q] <= in_is_head;
        end
    end

    // Outputs
    always_comb begin
        out_data    = '0;
        out_is_head = 1'b0;
        if (!empty) begin
            out_data    = mem_data_q[rd_ptr_q];
            out_is_head = mem_head_q[rd_ptr_q];
        end
    end

    assign err_pulse  = err_q;
    assign flit_count = flit_count_q;

endmodule
